lsq_unit: RTL and testbench

- Parametrised successor to the single-port load/store reservation unit.
- Holds up to ENTRIES memory ops. Captures operands from the common data bus (CDB). Issues the op whose target tag equals the ROB head to a valid/ready memory port.
- Returns load data or store completion to the ROB.
- New capabilities: allocation back-pressure, misalignment exception, pipeline flush with in-flight response drain, signed/unsigned sub-word loads at DATA_W.

---
 rtl/lsq_unit.sv | 194 +++++++++++++++++++
 tb/tb_lsq_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_unit.sv
// lsq_unit: load/store reservation unit that issues the op matching the ROB head to a single memory port
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_alloc_* / o_alloc_ready   op allocation with back-pressure
//   i_cdb_*                     result broadcast for operand capture
//   i_rob_head_valid/i_rob_head oldest uncommitted tag, gates issue
//   i_flush                     discard all entries and any in-flight op
//   o_req_* / i_req_ready       memory request, valid/ready
//   i_resp_valid/i_resp_rdata   memory response (load data or store ack)
//   o_out_*                     completion to the ROB, o_out_exc = misaligned
module lsq_unit #(
    parameter int ENTRIES = 4,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_alloc_valid,
    output logic              o_alloc_ready,
    input  logic [TAG_W-1:0]  i_alloc_target,
    input  logic [1:0]        i_alloc_op,
    input  logic [1:0]        i_alloc_size,
    input  logic [DATA_W-1:0] i_alloc_offset,
    input  logic [DATA_W-1:0] i_alloc_val1,
    input  logic [DATA_W-1:0] i_alloc_val2,
    input  logic [TAG_W-1:0]  i_alloc_tag1,
    input  logic [TAG_W-1:0]  i_alloc_tag2,
    input  logic              i_cdb_valid,
    input  logic [TAG_W-1:0]  i_cdb_tag,
    input  logic [DATA_W-1:0] i_cdb_val,
    input  logic              i_rob_head_valid,
    input  logic [TAG_W-1:0]  i_rob_head,
    input  logic              i_flush,
    output logic              o_req_valid,
    input  logic              i_req_ready,
    output logic              o_req_we,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic [1:0]        o_req_size,
    output logic [DATA_W-1:0] o_req_wdata,
    input  logic              i_resp_valid,
    input  logic [DATA_W-1:0] i_resp_rdata,
    output logic              o_out_valid,
    output logic [TAG_W-1:0]  o_out_tag,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_exc
);
    localparam int IW = $clog2(ENTRIES);
    localparam logic [TAG_W-1:0] INV = '1;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_target [ENTRIES];
    logic [TAG_W-1:0]   r_tag1 [ENTRIES];
    logic [TAG_W-1:0]   r_tag2 [ENTRIES];
    logic [1:0]         r_op [ENTRIES];
    logic [1:0]         r_size [ENTRIES];
    logic [DATA_W-1:0]  r_offset [ENTRIES];
    logic [DATA_W-1:0]  r_val1 [ENTRIES];
    logic [DATA_W-1:0]  r_val2 [ENTRIES];
    logic [IW-1:0]      r_idx;
    state_t             r_state, w_state_nxt;
    logic               r_out_valid, r_out_exc;
    logic [TAG_W-1:0]   r_out_tag;
    logic [DATA_W-1:0]  r_out_data;
    logic               w_free_found, w_sel_found, w_issue, w_exc, w_done, w_alloc, w_byp1, w_byp2;
    logic [IW-1:0]      w_free_idx, w_sel_idx;
    logic [2:0]         w_sel_lo;

    function automatic logic misaligned(input logic [2:0] a, input logic [1:0] sz);
        logic [3:0] m;
        m = (4'd1 << sz) - 4'd1;
        return |(a & m[2:0]);
    endfunction

    // Shift the sub-word to the top, then shift back arithmetically or logically.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d, input logic [1:0] op, input logic [1:0] sz);
        int sh;
        logic [DATA_W-1:0] t;
        logic signed [DATA_W-1:0] s;
        sh = (8 << sz) >= DATA_W ? 0 : DATA_W - (8 << sz);
        t = d << sh;
        s = $signed(t) >>> sh;
        return op == 2'd0 ? s : t >> sh;
    endfunction

    // Descending scan so the lowest index wins for both searches.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_sel_found  = 1'b0;
        w_sel_idx    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
            if (r_valid[i] && r_target[i] == i_rob_head && r_tag1[i] == INV && r_tag2[i] == INV) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IW'(i);
            end
        end
    end

    assign o_alloc_ready = w_free_found;
    assign w_sel_lo = 3'(r_val1[w_sel_idx] + r_offset[w_sel_idx]);
    assign w_issue  = r_state == S_IDLE && i_rob_head_valid && w_sel_found && !i_flush;
    assign w_exc    = w_issue && misaligned(w_sel_lo, r_size[w_sel_idx]);
    assign w_done   = r_state == S_WAIT && i_resp_valid;
    assign w_alloc  = i_alloc_valid && w_free_found && !i_flush;
    assign w_byp1   = i_cdb_valid && i_alloc_tag1 != INV && i_alloc_tag1 == i_cdb_tag;
    assign w_byp2   = i_cdb_valid && i_alloc_tag2 != INV && i_alloc_tag2 == i_cdb_tag;

    always_ff @(posedge clk) begin
        r_state <= rst ? S_IDLE : w_state_nxt;
    end

    // A response arriving together with a flush in WAIT is the one being drained.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = (w_issue && !w_exc) ? S_REQ : S_IDLE;
            S_REQ:   w_state_nxt = i_flush ? S_IDLE : (i_req_ready ? S_WAIT : S_REQ);
            S_WAIT:  w_state_nxt = i_resp_valid ? S_IDLE : (i_flush ? S_DRAIN : S_WAIT);
            S_DRAIN: w_state_nxt = i_resp_valid ? S_IDLE : S_DRAIN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Flush masks the request immediately so no handshake can slip through.
    always_comb begin
        o_req_valid = r_state == S_REQ && !i_flush;
        o_req_we    = r_op[r_idx] == 2'd2;
        o_req_addr  = ADDR_W'(r_val1[r_idx] + r_offset[r_idx]);
        o_req_size  = r_size[r_idx];
        o_req_wdata = r_val2[r_idx];
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (i_cdb_valid && r_valid[i] && r_tag1[i] != INV && r_tag1[i] == i_cdb_tag) begin
                    r_val1[i] <= i_cdb_val;
                    r_tag1[i] <= INV;
                end
                if (i_cdb_valid && r_valid[i] && r_tag2[i] != INV && r_tag2[i] == i_cdb_tag) begin
                    r_val2[i] <= i_cdb_val;
                    r_tag2[i] <= INV;
                end
            end
            if (w_alloc) begin
                r_valid[w_free_idx]  <= 1'b1;
                r_target[w_free_idx] <= i_alloc_target;
                r_op[w_free_idx]     <= i_alloc_op;
                r_size[w_free_idx]   <= i_alloc_size;
                r_offset[w_free_idx] <= i_alloc_offset;
                r_val1[w_free_idx]   <= w_byp1 ? i_cdb_val : i_alloc_val1;
                r_tag1[w_free_idx]   <= w_byp1 ? INV : i_alloc_tag1;
                r_val2[w_free_idx]   <= w_byp2 ? i_cdb_val : i_alloc_val2;
                r_tag2[w_free_idx]   <= w_byp2 ? INV : i_alloc_tag2;
            end
            if (w_exc) r_valid[w_sel_idx] <= 1'b0;
            if (w_done) r_valid[r_idx] <= 1'b0;
            if (w_issue) r_idx <= w_sel_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= INV;
            r_out_data  <= '0;
            r_out_exc   <= 1'b0;
        end else begin
            r_out_valid <= w_exc || (w_done && !i_flush);
            if (w_exc) begin
                r_out_tag  <= r_target[w_sel_idx];
                r_out_data <= '0;
                r_out_exc  <= 1'b1;
            end else if (w_done && !i_flush) begin
                r_out_tag  <= r_target[r_idx];
                r_out_data <= r_op[r_idx] == 2'd2 ? '0 : extend(i_resp_rdata, r_op[r_idx], r_size[r_idx]);
                r_out_exc  <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_tag   = r_out_tag;
    assign o_out_data  = r_out_data;
    assign o_out_exc   = r_out_exc;
endmodule

// File: tb/tb_lsq_unit.sv
// tb_lsq_unit: directed and randomized checks of lsq_unit against a behavioural model
module tb_lsq_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic alloc_valid = 0, alloc_ready;
    logic [3:0] alloc_target = 0, alloc_tag1 = 0, alloc_tag2 = 0;
    logic [1:0] alloc_op = 0, alloc_size = 0;
    logic [31:0] alloc_offset = 0, alloc_val1 = 0, alloc_val2 = 0;
    logic cdb_valid = 0;
    logic [3:0] cdb_tag = 0;
    logic [31:0] cdb_val = 0;
    logic rob_head_valid = 0;
    logic [3:0] rob_head = 0;
    logic flush = 0;
    logic req_valid, req_ready = 0, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [1:0] req_size;
    logic resp_valid = 0;
    logic [31:0] resp_rdata = 0;
    logic out_valid, out_exc;
    logic [3:0] out_tag;
    logic [31:0] out_data;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lsq_unit dut (
        .clk(clk), .rst(rst),
        .i_alloc_valid(alloc_valid), .o_alloc_ready(alloc_ready),
        .i_alloc_target(alloc_target), .i_alloc_op(alloc_op), .i_alloc_size(alloc_size),
        .i_alloc_offset(alloc_offset), .i_alloc_val1(alloc_val1), .i_alloc_val2(alloc_val2),
        .i_alloc_tag1(alloc_tag1), .i_alloc_tag2(alloc_tag2),
        .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag), .i_cdb_val(cdb_val),
        .i_rob_head_valid(rob_head_valid), .i_rob_head(rob_head), .i_flush(flush),
        .o_req_valid(req_valid), .i_req_ready(req_ready), .o_req_we(req_we),
        .o_req_addr(req_addr), .o_req_size(req_size), .o_req_wdata(req_wdata),
        .i_resp_valid(resp_valid), .i_resp_rdata(resp_rdata),
        .o_out_valid(out_valid), .o_out_tag(out_tag), .o_out_data(out_data), .o_out_exc(out_exc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Loaded value as the ROB should see it: masked to the access size, sign-filled for op 0.
    function automatic logic [31:0] mdata(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] rd);
        logic [31:0] m, v;
        if (op == 2'd2) return 32'd0;
        m = sz >= 2'd2 ? 32'hFFFF_FFFF : (32'd1 << (8 << sz)) - 32'd1;
        v = rd & m;
        if (op == 2'd0 && sz < 2'd2 && v > (m >> 1)) v = v | ~m;
        return v;
    endfunction

    task automatic alloc(input logic [3:0] tgt, input logic [1:0] op, input logic [1:0] sz,
                         input logic [31:0] off, input logic [31:0] v1, input logic [31:0] v2,
                         input logic [3:0] t1, input logic [3:0] t2, input logic cv,
                         input logic [3:0] ct, input logic [31:0] cval, input logic rdy);
        alloc_valid = 1'b1; alloc_target = tgt; alloc_op = op; alloc_size = sz; alloc_offset = off;
        alloc_val1 = v1; alloc_val2 = v2; alloc_tag1 = t1; alloc_tag2 = t2;
        cdb_valid = cv; cdb_tag = ct; cdb_val = cval;
        #1;
        chk("alloc_ready", alloc_ready, rdy);
        tick;
        alloc_valid = 1'b0;
        cdb_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        cdb_valid = 1'b1; cdb_tag = t; cdb_val = v;
        tick;
        cdb_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] tgt, input logic we, input logic [31:0] addr,
                         input logic [1:0] sz, input logic [31:0] wd, input logic mis,
                         input logic [31:0] rd, input logic [31:0] dat);
        int d;
        rob_head = tgt;
        rob_head_valid = 1'b1;
        tick;
        rob_head_valid = 1'b0;
        #1;
        if (mis) begin
            chk("exc_no_req", req_valid, 1'b0);
            chk("exc_valid", out_valid, 1'b1);
            chk("exc_flag", out_exc, 1'b1);
            chk("exc_tag", out_tag, tgt);
        end else begin
            chk("req_valid", req_valid, 1'b1);
            chk("req_we", req_we, we);
            chk("req_addr", req_addr, addr);
            chk("req_size", req_size, sz);
            if (we) chk("req_wdata", req_wdata, wd);
            d = $urandom_range(0, 2);
            for (int i = 0; i < d; i++) begin
                tick;
                chk("req_hold", req_valid, 1'b1);
                chk("req_addr_hold", req_addr, addr);
            end
            req_ready = 1'b1;
            tick;
            req_ready = 1'b0;
            #1;
            chk("req_done", req_valid, 1'b0);
            d = $urandom_range(0, 1);
            for (int i = 0; i < d; i++) begin
                tick;
                chk("wait_quiet", out_valid, 1'b0);
            end
            resp_valid = 1'b1;
            resp_rdata = rd;
            tick;
            resp_valid = 1'b0;
            #1;
            chk("out_valid", out_valid, 1'b1);
            chk("out_tag", out_tag, tgt);
            chk("out_data", out_data, dat);
            chk("out_exc", out_exc, 1'b0);
        end
        tick;
        chk("out_pulse", out_valid, 1'b0);
    endtask

    initial begin
        logic [1:0] rop [4];
        logic [1:0] rsz [4];
        logic [31:0] rb [4], ro [4], rw [4];
        logic pend1 [4], pend2 [4];
        int ord [4];
        int k, tmp, s;
        logic p1, p2, cv;
        logic [3:0] ct, pt1, pt2;
        logic [31:0] cval, a, rd;

        repeat (3) tick;
        rst = 1'b0;
        tick;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_tag", out_tag, 4'hF);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_exc", out_exc, 1'b0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_alloc_ready", alloc_ready, 1'b1);

        // Signed byte load.
        alloc(4'd5, 2'd0, 2'd0, 32'd3, 32'h1000, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        issue(4'd5, 1'b0, 32'h1003, 2'd0, 32'd0, 1'b0, 32'h0000_00F0, 32'hFFFF_FFF0);

        // Unsigned and signed half loads.
        alloc(4'd5, 2'd1, 2'd1, 32'd0, 32'h1000, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        issue(4'd5, 1'b0, 32'h1000, 2'd1, 32'd0, 1'b0, 32'h0000_F0F0, 32'h0000_F0F0);
        alloc(4'd5, 2'd0, 2'd1, 32'd0, 32'h1000, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        issue(4'd5, 1'b0, 32'h1000, 2'd1, 32'd0, 1'b0, 32'h0000_F0F0, 32'hFFFF_F0F0);

        // Store whose data producer broadcasts in the allocation cycle.
        alloc(4'd6, 2'd2, 2'd2, 32'd4, 32'h2000, 32'd0, 4'hF, 4'd7, 1'b1, 4'd7, 32'hDEAD_BEEF, 1'b1);
        issue(4'd6, 1'b1, 32'h2004, 2'd2, 32'hDEAD_BEEF, 1'b0, 32'h1234_5678, 32'd0);

        // Store waiting on its base until a later broadcast.
        alloc(4'd6, 2'd2, 2'd2, 32'd8, 32'd0, 32'h1234_5678, 4'd9, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        rob_head = 4'd6;
        rob_head_valid = 1'b1;
        tick;
        chk("opwait_no_req1", req_valid, 1'b0);
        tick;
        chk("opwait_no_req2", req_valid, 1'b0);
        chk("opwait_no_out", out_valid, 1'b0);
        cdb(4'd9, 32'h3000);
        #1;
        chk("opwait_capture_cycle", req_valid, 1'b0);
        issue(4'd6, 1'b1, 32'h3008, 2'd2, 32'h1234_5678, 1'b0, 32'd0, 32'd0);

        // Fill, back-pressure, refill into the freed slot.
        for (int i = 0; i < 4; i++)
            alloc(4'(i), 2'd1, 2'd2, 32'd0, 32'(256 * (i + 1)), 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        chk("full_not_ready", alloc_ready, 1'b0);
        alloc(4'd9, 2'd1, 2'd2, 32'd0, 32'h4000, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b0);
        issue(4'd1, 1'b0, 32'h200, 2'd2, 32'd0, 1'b0, 32'hCAFE_0001, 32'hCAFE_0001);
        chk("freed_ready", alloc_ready, 1'b1);
        alloc(4'd4, 2'd0, 2'd0, 32'd1, 32'h500, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        chk("refull_not_ready", alloc_ready, 1'b0);
        rob_head = 4'd9;
        rob_head_valid = 1'b1;
        tick;
        tick;
        chk("ignored_no_req", req_valid, 1'b0);
        chk("ignored_no_out", out_valid, 1'b0);
        rob_head_valid = 1'b0;
        issue(4'd0, 1'b0, 32'h100, 2'd2, 32'd0, 1'b0, 32'h8000_0000, 32'h8000_0000);
        issue(4'd4, 1'b0, 32'h501, 2'd0, 32'd0, 1'b0, 32'h0000_0080, 32'hFFFF_FF80);
        issue(4'd2, 1'b0, 32'h300, 2'd2, 32'd0, 1'b0, 32'h0000_0003, 32'h0000_0003);
        issue(4'd3, 1'b0, 32'h400, 2'd2, 32'd0, 1'b0, 32'h7777_7777, 32'h7777_7777);
        chk("drained_ready", alloc_ready, 1'b1);

        // Misaligned word load.
        alloc(4'd2, 2'd1, 2'd2, 32'd2, 32'h1000, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        issue(4'd2, 1'b0, 32'h1002, 2'd2, 32'd0, 1'b1, 32'd0, 32'd0);

        // Flush while waiting for the response, with an allocation in the same cycle.
        alloc(4'd1, 2'd1, 2'd2, 32'd0, 32'h600, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        rob_head = 4'd1;
        rob_head_valid = 1'b1;
        tick;
        rob_head_valid = 1'b0;
        req_ready = 1'b1;
        tick;
        req_ready = 1'b0;
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_target = 4'd2; alloc_op = 2'd1; alloc_size = 2'd2;
        alloc_offset = 32'd0; alloc_val1 = 32'h700; alloc_tag1 = 4'hF; alloc_tag2 = 4'hF;
        tick;
        flush = 1'b0;
        alloc_valid = 1'b0;
        #1;
        chk("flush_ready", alloc_ready, 1'b1);
        chk("flush_no_out", out_valid, 1'b0);
        resp_valid = 1'b1;
        resp_rdata = 32'h1111_1111;
        tick;
        resp_valid = 1'b0;
        #1;
        chk("drain_no_out", out_valid, 1'b0);
        tick;
        chk("drain_no_out2", out_valid, 1'b0);
        rob_head = 4'd2;
        rob_head_valid = 1'b1;
        tick;
        tick;
        chk("flushed_alloc_gone", req_valid, 1'b0);
        rob_head_valid = 1'b0;
        alloc(4'd3, 2'd0, 2'd1, 32'd2, 32'h800, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        issue(4'd3, 1'b0, 32'h802, 2'd1, 32'd0, 1'b0, 32'h0000_7FFF, 32'h0000_7FFF);

        // Flush while the request is still unacknowledged.
        alloc(4'd4, 2'd1, 2'd0, 32'd0, 32'h900, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        rob_head = 4'd4;
        rob_head_valid = 1'b1;
        tick;
        rob_head_valid = 1'b0;
        #1;
        chk("preflush_req", req_valid, 1'b1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        #1;
        chk("reqflush_drop", req_valid, 1'b0);
        tick;
        chk("reqflush_idle", req_valid, 1'b0);
        chk("reqflush_no_out", out_valid, 1'b0);
        alloc(4'd4, 2'd1, 2'd0, 32'd0, 32'h900, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        issue(4'd4, 1'b0, 32'h900, 2'd0, 32'd0, 1'b0, 32'h0000_00AB, 32'h0000_00AB);

        // Randomized batches: operands arrive by bypass, later capture, or are ready at alloc.
        for (int b = 0; b < 16; b++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                rop[j] = 2'($urandom_range(0, 2));
                rsz[j] = 2'($urandom_range(0, 2));
                rb[j] = $urandom;
                ro[j] = 32'($urandom_range(0, 7));
                rw[j] = $urandom;
                p1 = 1'($urandom_range(0, 1));
                p2 = 1'($urandom_range(0, 1));
                pt1 = 4'(8 + 2 * j);
                pt2 = 4'(9 + 2 * j);
                pend1[j] = p1;
                pend2[j] = p2;
                cv = 1'b0; ct = 4'd0; cval = 32'd0;
                if (p1 && $urandom_range(0, 1) == 1) begin
                    cv = 1'b1; ct = pt1; cval = rb[j]; pend1[j] = 1'b0;
                end else if (p2 && $urandom_range(0, 1) == 1) begin
                    cv = 1'b1; ct = pt2; cval = rw[j]; pend2[j] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    cv = 1'b1; ct = 4'($urandom_range(0, 7)); cval = $urandom;
                end
                alloc(4'(j), rop[j], rsz[j], ro[j], p1 ? $urandom : rb[j], p2 ? $urandom : rw[j],
                      p1 ? pt1 : 4'hF, p2 ? pt2 : 4'hF, cv, ct, cval, 1'b1);
                ord[j] = j;
            end
            chk("batch_ready", alloc_ready, k < 4);
            for (int j = 0; j < k; j++) begin
                if (pend1[j]) cdb(4'(8 + 2 * j), rb[j]);
                if (pend2[j]) cdb(4'(9 + 2 * j), rw[j]);
            end
            for (int i = k - 1; i > 0; i--) begin
                s = $urandom_range(0, i);
                tmp = ord[i]; ord[i] = ord[s]; ord[s] = tmp;
            end
            for (int i = 0; i < k; i++) begin
                s = ord[i];
                a = rb[s] + ro[s];
                rd = $urandom;
                issue(4'(s), rop[s] == 2'd2, a, rsz[s], rw[s], (a % (32'd1 << rsz[s])) != 0, rd,
                      mdata(rop[s], rsz[s], rd));
            end
            chk("batch_empty", alloc_ready, 1'b1);
        end

        // Reset in the middle of a request abandons everything.
        alloc(4'd5, 2'd1, 2'd2, 32'd0, 32'hA00, 32'd0, 4'hF, 4'hF, 1'b0, 4'd0, 32'd0, 1'b1);
        rob_head = 4'd5;
        rob_head_valid = 1'b1;
        tick;
        rob_head_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("midrst_req", req_valid, 1'b0);
        chk("midrst_ready", alloc_ready, 1'b1);
        chk("midrst_tag", out_tag, 4'hF);
        rob_head_valid = 1'b1;
        tick;
        tick;
        chk("midrst_entry_gone", req_valid, 1'b0);
        rob_head_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
